// File: rtl/multi_reg_sequencer.sv
// Block-transfer sequencer: walks a 16-bit register list in ascending order,
// presenting one register/address pair per Ack, then an optional base writeback.
module multi_reg_sequencer (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [15:0] RegList,
  input  logic [31:0] BaseAddr,
  input  logic        Up,
  input  logic        Before,
  input  logic        Writeback,
  input  logic        Ack,
  output logic        Busy,
  output logic        XferValid,
  output logic [3:0]  RegNum,
  output logic [31:0] Addr,
  output logic [4:0]  Remaining,
  output logic        WbValid,
  output logic [31:0] WbAddr,
  output logic        Done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] XFER = 2'd1;
  localparam logic [1:0] WB   = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]  state;
  logic [15:0] pending;
  logic [31:0] base;
  logic        upQ;
  logic        wbQ;
  logic [4:0]  count;

  logic [4:0]  startCount;
  logic [31:0] startFour;
  logic [31:0] startAddr;
  logic [31:0] countFour;
  logic [31:0] wbNext;
  logic [3:0]  lowIdx;

  always_comb begin
    startCount = '0;
    for (int unsigned k = 0; k < 16; k++) begin
      startCount = startCount + {4'b0000, RegList[k]};
    end
  end

  // 4n is at most 64, so the 7-bit product zero-extends cleanly to 32 bits
  assign startFour = {25'b0, startCount, 2'b00};
  assign countFour = {25'b0, count, 2'b00};

  always_comb begin
    case ({Before, Up})
      2'b01:   startAddr = BaseAddr;
      2'b11:   startAddr = BaseAddr + 32'd4;
      2'b00:   startAddr = BaseAddr - startFour + 32'd4;
      default: startAddr = BaseAddr - startFour;
    endcase
  end

  assign wbNext = upQ ? (base + countFour) : (base - countFour);

  // Scanning from the top down leaves the lowest set index as the final value
  always_comb begin
    lowIdx = '0;
    for (int unsigned k = 0; k < 16; k++) begin
      if (pending[15 - k]) lowIdx = 4'(15 - k);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      pending   <= '0;
      base      <= '0;
      upQ       <= 1'b0;
      wbQ       <= 1'b0;
      count     <= '0;
      Addr      <= '0;
      Remaining <= '0;
      WbAddr    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            pending   <= RegList;
            base      <= BaseAddr;
            upQ       <= Up;
            wbQ       <= Writeback;
            count     <= startCount;
            Remaining <= startCount;
            Addr      <= startAddr;
            state     <= (startCount == 5'd0) ? DONE : XFER;
          end
        end
        XFER: begin
          if (Ack) begin
            pending   <= pending & ~(16'd1 << lowIdx);
            Addr      <= Addr + 32'd4;
            Remaining <= Remaining - 5'd1;
            if (Remaining == 5'd1) begin
              // Writeback value is registered on entry so it is valid during WB
              if (wbQ) begin
                WbAddr <= wbNext;
                state  <= WB;
              end else begin
                state  <= DONE;
              end
            end
          end
        end
        WB:      state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

  assign Busy      = (state != IDLE);
  assign XferValid = (state == XFER);
  assign WbValid   = (state == WB);
  assign Done      = (state == DONE);
  assign RegNum    = XferValid ? lowIdx : '0;

endmodule

// File: tb/tb_multi_reg_sequencer.sv
// Scoreboard bench for multi_reg_sequencer: stimulus queues expected transfers,
// writebacks and completions; a negedge monitor pops and compares them.
module tb_multi_reg_sequencer;

  logic        Clk = 1'b0;
  logic        Reset, Start, Up, Before, Writeback, Ack;
  logic [15:0] RegList;
  logic [31:0] BaseAddr;
  logic        Busy, XferValid, WbValid, Done;
  logic [3:0]  RegNum;
  logic [31:0] Addr, WbAddr;
  logic [4:0]  Remaining;

  always #5 Clk = ~Clk;

  multi_reg_sequencer dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .RegList(RegList),
    .BaseAddr(BaseAddr), .Up(Up), .Before(Before), .Writeback(Writeback),
    .Ack(Ack), .Busy(Busy), .XferValid(XferValid), .RegNum(RegNum),
    .Addr(Addr), .Remaining(Remaining), .WbValid(WbValid), .WbAddr(WbAddr),
    .Done(Done)
  );

  typedef struct {
    int          kind;   // 0 transfer, 1 writeback, 2 done
    logic [3:0]  r;
    logic [31:0] a;
    logic [4:0]  rem;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  bit          monOn = 1'b0;
  logic [31:0] expWbHold = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic pushX(input logic [3:0] r, input logic [31:0] a, input logic [4:0] rem);
    exp_t e;
    e.kind = 0; e.r = r; e.a = a; e.rem = rem;
    q.push_back(e);
  endtask

  task automatic pushWb(input logic [31:0] a);
    exp_t e;
    e.kind = 1; e.r = '0; e.a = a; e.rem = '0;
    q.push_back(e);
  endtask

  task automatic pushDone();
    exp_t e;
    e.kind = 2; e.r = '0; e.a = '0; e.rem = '0;
    q.push_back(e);
  endtask

  // Monitor
  always @(negedge Clk) begin
    exp_t e;
    if (monOn && !Reset) begin
      chk("exclusive", 32'(XferValid) + 32'(WbValid) + 32'(Done), (XferValid | WbValid | Done) ? 32'd1 : 32'd0);
      if (!XferValid) chk("regnum_idle", 32'(RegNum), 32'd0);
      if (XferValid && Ack) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_xfer: got R%0d@%0h want none", RegNum, Addr);
        end else begin
          e = q.pop_front();
          chk("xfer_kind", 32'd0, 32'(e.kind));
          chk("xfer_reg", 32'(RegNum), 32'(e.r));
          chk("xfer_addr", Addr, e.a);
          chk("xfer_rem", 32'(Remaining), 32'(e.rem));
        end
      end
      if (WbValid) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_wb: got %0h want none", WbAddr);
        end else begin
          e = q.pop_front();
          chk("wb_kind", 32'd1, 32'(e.kind));
          chk("wb_addr", WbAddr, e.a);
          expWbHold = e.a;
        end
      end else begin
        chk("wbaddr_hold", WbAddr, expWbHold);
      end
      if (Done) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done: got 1 want 0");
        end else begin
          e = q.pop_front();
          chk("done_kind", 32'd2, 32'(e.kind));
        end
      end
    end
  end

  // Returns after the Start edge, 1ns past it; inputs are then scrambled.
  task automatic startSeq(input logic [15:0] l, input logic [31:0] b,
                          input logic p, input logic u, input logic w);
    @(posedge Clk); #1;
    RegList = l; BaseAddr = b; Before = p; Up = u; Writeback = w; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    RegList = 16'($urandom); BaseAddr = $urandom;
    Before = 1'($urandom); Up = 1'($urandom); Writeback = 1'($urandom);
  endtask

  task automatic waitDone(input int limit, output int cyc);
    cyc = 0;
    while (1) begin
      @(negedge Clk);
      cyc++;
      if (Done) break;
      if (cyc >= limit) begin
        total++; bad++;
        $display("FAIL done_timeout: got no Done want Done within %0d cycles", limit);
        break;
      end
    end
  endtask

  task automatic checkAllZero(input string nm);
    chk({nm, "_busy"}, 32'(Busy), 32'd0);
    chk({nm, "_xv"}, 32'(XferValid), 32'd0);
    chk({nm, "_wv"}, 32'(WbValid), 32'd0);
    chk({nm, "_done"}, 32'(Done), 32'd0);
    chk({nm, "_reg"}, 32'(RegNum), 32'd0);
    chk({nm, "_addr"}, Addr, 32'd0);
    chk({nm, "_rem"}, 32'(Remaining), 32'd0);
    chk({nm, "_wbaddr"}, WbAddr, 32'd0);
  endtask

  task automatic runIA();
    int cyc;
    pushX(4'd0, 32'h1000, 5'd3);
    pushX(4'd4, 32'h1004, 5'd2);
    pushX(4'd11, 32'h1008, 5'd1);
    pushWb(32'h100C);
    pushDone();
    startSeq(16'h0811, 32'h1000, 1'b0, 1'b1, 1'b1);
    waitDone(20, cyc);
    chk("ia_done_latency", 32'(cyc), 32'd5);
    @(negedge Clk);
    chk("ia_idle_busy", 32'(Busy), 32'd0);
    chk("ia_q_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    int cyc;
    Reset = 1'b1; Start = 1'b1; Ack = 1'b1; RegList = 16'hFFFF;
    BaseAddr = 32'h1234; Up = 1'b1; Before = 1'b0; Writeback = 1'b1;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    checkAllZero("reset");
    @(posedge Clk); #1;
    Reset = 1'b0; Start = 1'b0;
    monOn = 1'b1;

    // IA with writeback, Ack held high throughout
    runIA();

    // DB; Start raised in the DONE cycle must be ignored
    pushX(4'd0, 32'h1FF4, 5'd3);
    pushX(4'd1, 32'h1FF8, 5'd2);
    pushX(4'd15, 32'h1FFC, 5'd1);
    pushWb(32'h1FF4);
    pushDone();
    startSeq(16'h8003, 32'h2000, 1'b1, 1'b0, 1'b1);
    waitDone(20, cyc);
    Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    @(negedge Clk);
    chk("db_start_in_done_ignored", 32'(Busy), 32'd0);
    chk("db_q_empty", 32'(q.size()), 32'd0);

    // DA full list, with a stray Start mid-transfer
    for (int k = 0; k < 16; k++) pushX(4'(k), 32'h0C4 + 32'(4 * k), 5'(16 - k));
    pushDone();
    startSeq(16'hFFFF, 32'h100, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge Clk);
    #1 Start = 1'b1; RegList = 16'h0001; BaseAddr = 32'h9000;
    @(posedge Clk); #1;
    Start = 1'b0;
    waitDone(40, cyc);
    @(negedge Clk);
    chk("da_idle_busy", 32'(Busy), 32'd0);
    chk("da_q_empty", 32'(q.size()), 32'd0);

    // Empty list
    pushDone();
    startSeq(16'h0000, 32'h4000, 1'b1, 1'b1, 1'b1);
    waitDone(10, cyc);
    chk("empty_done_latency", 32'(cyc), 32'd1);
    @(negedge Clk);
    chk("empty_idle_busy", 32'(Busy), 32'd0);
    chk("empty_q_empty", 32'(q.size()), 32'd0);

    // Ack stall on R1
    pushX(4'd1, 32'h3000, 5'd2);
    pushX(4'd2, 32'h3004, 5'd1);
    pushDone();
    startSeq(16'h0006, 32'h3000, 1'b0, 1'b1, 1'b0);
    Ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      chk("stall_reg", 32'(RegNum), 32'd1);
      chk("stall_addr", Addr, 32'h3000);
      @(posedge Clk); #1;
    end
    Ack = 1'b1;
    @(negedge Clk);
    chk("stall_reg_last", 32'(RegNum), 32'd1);
    chk("stall_addr_last", Addr, 32'h3000);
    waitDone(20, cyc);
    @(negedge Clk);
    chk("stall_q_empty", 32'(q.size()), 32'd0);

    // Reset during the 2nd transfer of the IA sequence, Ack high alongside
    pushX(4'd0, 32'h1000, 5'd3);
    startSeq(16'h0811, 32'h1000, 1'b0, 1'b1, 1'b1);
    @(negedge Clk);
    @(posedge Clk); #1;
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    expWbHold = '0;
    @(negedge Clk);
    checkAllZero("midreset");
    chk("midreset_q_empty", 32'(q.size()), 32'd0);
    repeat (3) @(negedge Clk);
    runIA();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want completion by 200000");
    $fatal(1);
  end

endmodule
